// File: rtl/ntt_result_unloader_if.sv
`default_nettype none
// ============================================================================
// Module   : ntt_result_unloader_if
// Purpose  : Coefficient output stream (valid/ready) of the NTT result
//            unloader. The producer uses the master modport, the consumer
//            uses the slave modport.
// Revision : 1.0 - initial release
// ============================================================================
interface ntt_result_unloader_if #(
  parameter int DATA_W = 16
) ();
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;

  modport master (
    output out_data,
    output out_valid,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_valid,
    input  out_last,
    output out_ready
  );
endinterface
`default_nettype wire

// File: rtl/ntt_result_unloader.sv
`default_nettype none
// ============================================================================
// Module   : ntt_result_unloader
// Purpose  : Reads the final NTT coefficients from one ping-pong bank pair
//            through the RAM B ports and streams them in order over a
//            valid/ready interface, with a 2-entry FIFO absorbing the
//            1-cycle RAM latency and downstream backpressure.
// Revision : 1.0 - initial release
// ============================================================================
module ntt_result_unloader #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 7,
  parameter int NCOEF  = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              unload_start,
  input  logic              result_sel,
  output logic              ram0_enb,
  output logic              ram1_enb,
  output logic              ram2_enb,
  output logic              ram3_enb,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] ram0_doutb,
  input  logic [DATA_W-1:0] ram1_doutb,
  input  logic [DATA_W-1:0] ram2_doutb,
  input  logic [DATA_W-1:0] ram3_doutb,
  output logic              busy,
  output logic              unload_done,
  ntt_result_unloader_if.master out_if
);

  localparam int                CNT_W  = ADDR_W + 1;
  localparam logic [CNT_W-1:0]  C_LAST = CNT_W'(NCOEF - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic                sel_q, sel_d;
  logic [CNT_W-1:0]    rd_cnt_q, rd_cnt_d;
  logic [CNT_W-1:0]    out_cnt_q, out_cnt_d;
  logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
  logic                inflight_q, inflight_d;
  logic [1:0]          bank_q, bank_d;
  logic [DATA_W-1:0]   head_data_q, head_data_d;
  logic                head_vld_q, head_vld_d;
  logic [DATA_W-1:0]   skid_data_q, skid_data_d;
  logic                skid_vld_q, skid_vld_d;

  logic                pop;
  logic                issue;
  logic                credit_ok;
  logic [1:0]          occupancy;
  logic [1:0]          issue_bank;
  logic [DATA_W-1:0]   wr_data;

  // Words held or on their way: FIFO entries plus the read returning now.
  assign pop        = head_vld_q & out_if.out_ready;
  assign occupancy  = {1'b0, head_vld_q} + {1'b0, skid_vld_q} + {1'b0, inflight_q};
  assign credit_ok  = ({1'b0, occupancy}) < (3'd2 + {2'b0, pop});
  // Bank index: pair select in the high bit, upper/lower half in the low bit.
  assign issue_bank = {sel_q, rd_cnt_q[ADDR_W]};

  // FSM next state, read issue and counter updates.
  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    rd_cnt_d   = rd_cnt_q;
    out_cnt_d  = out_cnt_q + {{ADDR_W{1'b0}}, pop};
    issue      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (unload_start) begin
          sel_d     = result_sel;
          rd_cnt_d  = '0;
          out_cnt_d = '0;
          state_d   = ST_RUN;
        end
      end
      ST_RUN: begin
        if (credit_ok) begin
          issue    = 1'b1;
          rd_cnt_d = rd_cnt_q + 1'b1;
          if (rd_cnt_q == C_LAST) begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (pop && (out_cnt_q == C_LAST)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    inflight_d = issue;
    bank_d     = issue ? issue_bank : bank_q;
    rd_addr_d  = issue ? rd_cnt_q[ADDR_W-1:0] : rd_addr_q;
  end

  // Returning word comes from the bank latched when its read was issued.
  always_comb begin
    wr_data = ram0_doutb;
    unique case (bank_q)
      2'd0: wr_data = ram0_doutb;
      2'd1: wr_data = ram1_doutb;
      2'd2: wr_data = ram2_doutb;
      2'd3: wr_data = ram3_doutb;
      default: wr_data = ram0_doutb;
    endcase
  end

  // Two-entry FIFO: head drives the stream, skid catches the word that
  // returns while the head is stalled.
  always_comb begin
    head_data_d = head_data_q;
    head_vld_d  = head_vld_q;
    skid_data_d = skid_data_q;
    skid_vld_d  = skid_vld_q;
    if (pop) begin
      if (skid_vld_q) begin
        head_data_d = skid_data_q;
        head_vld_d  = 1'b1;
        skid_vld_d  = inflight_q;
        if (inflight_q) begin
          skid_data_d = wr_data;
        end
      end else begin
        head_vld_d = inflight_q;
        if (inflight_q) begin
          head_data_d = wr_data;
        end
      end
    end else if (inflight_q) begin
      if (!head_vld_q) begin
        head_vld_d  = 1'b1;
        head_data_d = wr_data;
      end else begin
        skid_vld_d  = 1'b1;
        skid_data_d = wr_data;
      end
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      sel_q       <= 1'b0;
      rd_cnt_q    <= '0;
      out_cnt_q   <= '0;
      rd_addr_q   <= '0;
      inflight_q  <= 1'b0;
      bank_q      <= 2'd0;
      head_data_q <= '0;
      head_vld_q  <= 1'b0;
      skid_data_q <= '0;
      skid_vld_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      rd_cnt_q    <= rd_cnt_d;
      out_cnt_q   <= out_cnt_d;
      rd_addr_q   <= rd_addr_d;
      inflight_q  <= inflight_d;
      bank_q      <= bank_d;
      head_data_q <= head_data_d;
      head_vld_q  <= head_vld_d;
      skid_data_q <= skid_data_d;
      skid_vld_q  <= skid_vld_d;
    end
  end

  assign ram0_enb = issue && (issue_bank == 2'd0);
  assign ram1_enb = issue && (issue_bank == 2'd1);
  assign ram2_enb = issue && (issue_bank == 2'd2);
  assign ram3_enb = issue && (issue_bank == 2'd3);
  assign rd_addr  = rd_addr_d;

  assign out_if.out_data  = head_data_q;
  assign out_if.out_valid = head_vld_q;
  assign out_if.out_last  = head_vld_q && (out_cnt_q == C_LAST);

  assign busy        = (state_q != ST_IDLE);
  assign unload_done = (state_q == ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_ntt_result_unloader.sv
`default_nettype none
// ============================================================================
// Module   : tb_ntt_result_unloader
// Purpose  : Self-checking bench for ntt_result_unloader: RAM models, a
//            behavioural stream/read model, and directed plus random-ready
//            unload scenarios.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ntt_result_unloader;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 7;
  localparam int DEPTH  = 128;
  localparam int NCOEF  = 256;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              unload_start = 1'b0;
  logic              result_sel = 1'b0;
  logic              ram0_enb, ram1_enb, ram2_enb, ram3_enb;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] ram0_doutb = '0, ram1_doutb = '0, ram2_doutb = '0, ram3_doutb = '0;
  logic              busy, unload_done;

  ntt_result_unloader_if #(.DATA_W(DATA_W)) out_if ();

  ntt_result_unloader #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NCOEF(NCOEF)) dut (
    .clk(clk), .rst_n(rst_n), .unload_start(unload_start), .result_sel(result_sel),
    .ram0_enb(ram0_enb), .ram1_enb(ram1_enb), .ram2_enb(ram2_enb), .ram3_enb(ram3_enb),
    .rd_addr(rd_addr),
    .ram0_doutb(ram0_doutb), .ram1_doutb(ram1_doutb),
    .ram2_doutb(ram2_doutb), .ram3_doutb(ram3_doutb),
    .busy(busy), .unload_done(unload_done),
    .out_if(out_if)
  );

  always #5 clk = ~clk;

  logic [DATA_W-1:0] mem0 [DEPTH];
  logic [DATA_W-1:0] mem1 [DEPTH];
  logic [DATA_W-1:0] mem2 [DEPTH];
  logic [DATA_W-1:0] mem3 [DEPTH];

  // Synchronous-read RAM B ports.
  always @(posedge clk) begin
    if (ram0_enb) ram0_doutb <= mem0[rd_addr];
    if (ram1_enb) ram1_doutb <= mem1[rd_addr];
    if (ram2_enb) ram2_doutb <= mem2[rd_addr];
    if (ram3_enb) ram3_doutb <= mem3[rd_addr];
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DATA_W-1:0] exp_coef(input bit sel, input int c);
    if (c < DEPTH) return sel ? mem2[c] : mem0[c];
    else           return sel ? mem3[c - DEPTH] : mem1[c - DEPTH];
  endfunction

  // ---------------- behavioural model + compare process ----------------
  int                beat = 0, issued = 0, accepted = 0, since = 0, done_cnt = 0;
  bit                m_busy = 0, m_active = 0, m_sel = 0, exp_done = 0;
  bit                prev_stall = 0, seen_first = 0, exp_done_next;
  logic [DATA_W-1:0] prev_data = '0;
  logic              prev_last = 1'b0;
  logic [ADDR_W-1:0] last_addr = '0;
  logic [DATA_W-1:0] got [NCOEF];
  logic [3:0]        en;

  always @(negedge clk) begin
    en = {ram3_enb, ram2_enb, ram1_enb, ram0_enb};
    if (!rst_n) begin
      chk("reset_outputs",
          {en, out_if.out_valid, out_if.out_last, busy, unload_done, rd_addr, out_if.out_data},
          32'd0);
      beat = 0; issued = 0; accepted = 0; since = 0;
      m_busy = 0; m_active = 0; exp_done = 0;
      prev_stall = 0; seen_first = 0; last_addr = '0;
    end else begin
      if (m_active) since++;
      chk("enb_onehot", ($countones(en) <= 1), 1);
      chk("busy", busy, m_busy);
      chk("unload_done", unload_done, exp_done);
      chk("outstanding_le2", ((issued - accepted) <= 2), 1);
      if (en != 4'd0) begin
        chk("read_when_active", m_active, 1);
        chk("read_count", (issued < NCOEF), 1);
        chk("rd_bank", en, 4'b0001 << (2 * int'(m_sel) + ((issued >= DEPTH) ? 1 : 0)));
        chk("rd_addr", rd_addr, issued % DEPTH);
        issued++;
        last_addr = rd_addr;
      end else begin
        chk("rd_addr_hold", rd_addr, last_addr);
      end
      if (prev_stall) begin
        chk("stall_valid", out_if.out_valid, 1);
        chk("stall_data", out_if.out_data, prev_data);
        chk("stall_last", out_if.out_last, prev_last);
      end
      exp_done_next = 0;
      if (out_if.out_valid) begin
        chk("valid_when_active", m_active, 1);
        if (!seen_first) begin
          chk("first_valid_latency", since, 3);
          seen_first = 1;
        end
        chk("beat_in_range", (beat < NCOEF), 1);
        chk("out_data", out_if.out_data, exp_coef(m_sel, beat));
        chk("out_last", out_if.out_last, (beat == NCOEF - 1));
        if (out_if.out_ready) begin
          if (beat < NCOEF) got[beat] = out_if.out_data;
          if (beat == NCOEF - 1) exp_done_next = 1;
          beat++;
          accepted++;
        end
      end else begin
        chk("last_without_valid", out_if.out_last, 0);
      end
      prev_stall = out_if.out_valid && !out_if.out_ready;
      prev_data  = out_if.out_data;
      prev_last  = out_if.out_last;
      if (unload_done) begin
        done_cnt++;
        chk("beats_at_done", beat, NCOEF);
      end
      if (exp_done) begin
        m_busy = 0;
        m_active = 0;
      end
      exp_done = exp_done_next;
      if (!m_busy && unload_start) begin
        m_busy = 1; m_active = 1; m_sel = result_sel;
        beat = 0; issued = 0; accepted = 0; since = 0; seen_first = 0;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic pulse_start(input bit sel);
    @(posedge clk); #1;
    result_sel = sel;
    unload_start = 1'b1;
    @(posedge clk); #1;
    unload_start = 1'b0;
  endtask

  // mode 0: ready held high, mode 1: random 50% ready
  task automatic wait_done(input int mode);
    int n0;
    n0 = done_cnt;
    for (int i = 0; i < 3000 && done_cnt == n0; i++) begin
      @(posedge clk); #1;
      if (mode == 1) out_if.out_ready = 1'($urandom_range(0, 1));
    end
    chk("unload_done_seen", (done_cnt > n0), 1);
    out_if.out_ready = 1'b1;
  endtask

  task automatic wait_beat(input int b);
    int i;
    for (i = 0; i < 2000 && beat != b; i++) begin
      @(posedge clk); #1;
    end
    chk("reach_beat", beat, b);
  endtask

  initial begin
    int n0;
    out_if.out_ready = 1'b1;
    for (int k = 0; k < DEPTH; k++) begin
      mem0[k] = DATA_W'(k);
      mem1[k] = DATA_W'(16'h0100 + k);
      mem2[k] = DATA_W'($urandom);
      mem3[k] = DATA_W'($urandom);
    end
    mem2[0]         = 16'hA5A5;
    mem3[DEPTH - 1] = 16'h5A5A;

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // 1: pair 0/1, ready always high
    pulse_start(1'b0);
    wait_done(0);
    chk("pin_beat0",   got[0],   16'h0000);
    chk("pin_beat127", got[127], 16'h007F);
    chk("pin_beat128", got[128], 16'h0100);
    chk("pin_beat255", got[255], 16'h017F);
    repeat (3) @(posedge clk);

    // 2: pair 2/3
    pulse_start(1'b1);
    wait_done(0);
    chk("pin_sel1_beat0",   got[0],   16'hA5A5);
    chk("pin_sel1_beat255", got[255], 16'h5A5A);
    repeat (3) @(posedge clk);

    // 3: stall 10 cycles at beat 50
    pulse_start(1'b0);
    wait_beat(50);
    out_if.out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("stall50_valid", out_if.out_valid, 1);
      chk("stall50_data", out_if.out_data, 16'h0032);
    end
    out_if.out_ready = 1'b1;
    wait_done(0);
    repeat (3) @(posedge clk);

    // 4: random ready, both pairs
    pulse_start(1'b1);
    wait_done(1);
    repeat (2) @(posedge clk);
    pulse_start(1'b0);
    wait_done(1);
    repeat (3) @(posedge clk);

    // 5: second start during RUN is ignored
    n0 = done_cnt;
    pulse_start(1'b0);
    repeat (40) @(posedge clk);
    pulse_start(1'b1);
    wait_done(0);
    repeat (10) @(posedge clk);
    chk("single_done", done_cnt, n0 + 1);

    // 6: reset at beat 100, then restart from coefficient 0
    pulse_start(1'b1);
    wait_beat(100);
    rst_n = 1'b0;
    #1;
    chk("rst_async_valid", out_if.out_valid, 0);
    chk("rst_async_busy", busy, 0);
    chk("rst_async_enb", {ram3_enb, ram2_enb, ram1_enb, ram0_enb}, 4'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    pulse_start(1'b0);
    wait_done(0);
    chk("restart_beat0",   got[0],   16'h0000);
    chk("restart_beat255", got[255], 16'h017F);
    repeat (3) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ntt_result_unloader.md
Name: ntt_result_unloader

Overview:
- Reads the final NTT result out of the ping-pong coefficient RAMs after the last butterfly stage and streams it to the host side as an ordered coefficient stream with valid/ready handshake.
- It is the read-side counterpart of the stage address generator, which fills the banks: it reads the bank pair holding the final stage's results through the RAM B ports, absorbs the 1-cycle RAM read latency, and tolerates arbitrary downstream backpressure.

Parameters:
- DATA_W, 16, coefficient width in bits.
- ADDR_W, 7, RAM address width; DEPTH = 2**ADDR_W words per bank.
- NCOEF, 256, coefficients per polynomial; fixed at 2*DEPTH.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- unload_start  input  1  single-cycle pulse from NTT control after the final stage completes.
- result_sel  input  1  sampled with unload_start. 0: results are in ram0/ram1. 1: results are in ram2/ram3.
- ram0_enb, ram1_enb, ram2_enb, ram3_enb  output  1 each  B-port read enables.
- rd_addr  output  ADDR_W  shared B-port read address.
- ram0_doutb, ram1_doutb, ram2_doutb, ram3_doutb  input  DATA_W each  B-port read data, valid one cycle after the enable.
- out_data  output  DATA_W  coefficient stream data.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  downstream accepts.
- out_last  output  1  marks coefficient NCOEF-1.
- busy  output  1  high from the cycle after unload_start is accepted until unload_done.
- unload_done  output  1  single-cycle pulse after the last handshake.

Behaviour:
- Reset values: all enables 0, rd_addr 0, out_valid 0, out_last 0, out_data 0, busy 0, unload_done 0. FSM is in IDLE; counters and FIFO are cleared.
- Mapping: coefficient c (0..NCOEF-1) is read from the lower bank of the selected pair (ram0 or ram2) when c < DEPTH, otherwise from the upper bank (ram1 or ram3). The address is c mod DEPTH.
- Read counter rd_cnt and output counter out_cnt are ADDR_W+1 bits wide.
- FSM states:
  - IDLE: when unload_start=1, latch result_sel, clear counters, go to RUN. unload_start in any other state is ignored.
  - RUN: issue one read per cycle while credit permits. After issuing c=NCOEF-1, go to DRAIN.
  - DRAIN: no new reads. When the handshake with out_last=1 completes, go to DONE.
  - DONE: unload_done=1 for exactly one cycle, then return to IDLE.
- Exactly one bank enable is high in a read cycle; all enables are 0 otherwise. rd_addr holds its value when no read is issued.
- Buffering: 2-entry output FIFO, head register drives out_data/out_valid, plus a 1-bit inflight flag.
  - Issue a read only when fifo_count + inflight - pop < 2, where pop = out_valid & out_ready. This guarantees no overflow.
  - The returning word is written into the FIFO on the cycle after issue, using the latched bank select.
- Latency: with unload_start sampled at edge T, the first read issues in cycle T+1 and out_valid rises at T+3.
- Throughput: with out_ready held high, sustained throughput is 1 coefficient/cycle.
- Handshake rules:
  - Once out_valid is asserted, out_valid, out_data and out_last stay stable until out_ready=1.
  - out_valid never depends combinationally on out_ready.
- out_last=1 only on the beat with out_cnt=NCOEF-1. Exactly NCOEF beats are produced per unload.
- busy: 1 in RUN, DRAIN and DONE.
- Reset mid-operation: returns immediately to the reset state. Data still in flight is discarded. Stalled out_valid drops without a handshake.
- result_sel changing during RUN/DRAIN has no effect.

Test Plan:
- Bank pair 0/1 loaded with ram0[k]=k, ram1[k]=0x100+k; result_sel=0; out_ready=1 → out_valid rises 3 cycles after unload_start; 256 consecutive beats 0x000..0x07F then 0x100..0x17F; out_last on beat 255; unload_done the following cycle.
- result_sel=1 with ram2/ram3 preloaded with distinct data → the stream comes only from ram2 then ram3; ram0_enb/ram1_enb stay 0 throughout.
- out_ready low for 10 cycles at beat 50 → out_data holds value 50 and out_valid stays 1. No more than 2 reads are issued past beat 50. After release, the stream continues with no gap, loss or duplicate.
- Random 50% out_ready → exactly 256 ordered beats; the checker never sees FIFO overflow and never sees more than one enable high in a cycle.
- Second unload_start pulse during RUN → ignored: a single stream and a single unload_done.
- rst_n asserted at beat 100 → out_valid, busy and all enables go 0 immediately. A new unload_start after release restarts from coefficient 0.
